// File: rtl/fifo_uart_tx.sv
// fifo_uart_tx -- pops bytes from a sync_fifo and serialises each one as an
// asynchronous UART frame: start bit, 8 data bits LSB first, optional parity
// bit, then one or two stop bits.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per UART bit (>= 2)
//   PARITY_EN     1 = parity bit after D7
//   PARITY_ODD    0 = even parity, 1 = odd parity
//   STOP_BITS     1 or 2
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous, active-high reset
//   tx_enable     1 = a new frame may start (looked at only while idle)
//   fifo_empty    FIFO has no data
//   fifo_rd_data  FIFO read data, valid the cycle after a pop
//   fifo_rd_en    one-cycle pop request to the FIFO
//   tx            serial line, idle high, driven from a flop
//   busy          high from the pop cycle to the end of the last stop bit
//   frame_done    one-cycle pulse on the last cycle of the last stop bit
module fifo_uart_tx #(
   parameter int CLKS_PER_BIT = 868,
   parameter int PARITY_EN    = 0,
   parameter int PARITY_ODD   = 0,
   parameter int STOP_BITS    = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       tx_enable,
   input  logic       fifo_empty,
   input  logic [7:0] fifo_rd_data,
   output logic       fifo_rd_en,
   output logic       tx,
   output logic       busy,
   output logic       frame_done
);

   localparam int                BAUD_W    = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
   localparam logic [BAUD_W-1:0] BAUD_PRE  = BAUD_W'(CLKS_PER_BIT - 2);
   localparam logic              STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LOAD   = 3'd1,
      START  = 3'd2,
      DATA   = 3'd3,
      PARITY = 3'd4,
      STOP   = 3'd5
   } state_t;

   state_t              state_q;
   logic [BAUD_W-1:0]   baud_q;
   logic [2:0]          bit_q;
   logic                stop_q;
   logic [7:0]          shreg_q;
   logic                par_q;
   logic                tx_q;
   logic                done_q;

   logic                pop_d;
   logic                parity_d;
   logic                bit_end_d;

   // Pop is masked by reset so no read is requested while reset is held,
   // which also covers the release edge.
   assign pop_d      = (state_q == IDLE) & tx_enable & ~fifo_empty & ~reset;
   assign parity_d   = (^fifo_rd_data) ^ (PARITY_ODD != 0);
   assign bit_end_d  = (baud_q == BAUD_LAST);

   assign fifo_rd_en = pop_d;
   assign busy       = (state_q != IDLE) | pop_d;
   assign tx         = tx_q;
   assign frame_done = done_q;

   // tx_q always holds the value of the bit being sent in the current cycle,
   // so it is loaded one edge ahead with the level of the next state.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         stop_q  <= 1'b0;
         shreg_q <= '0;
         par_q   <= 1'b0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         // Registered pulse: raised one cycle early so it lands on the final stop cycle.
         done_q <= (state_q == STOP) && (baud_q == BAUD_PRE) && (stop_q == STOP_LAST);
         case (state_q)
            IDLE: begin
               tx_q <= 1'b1;
               if (pop_d) begin
                  state_q <= LOAD;
               end
            end
            LOAD: begin
               // FIFO data became valid on the pop edge; capture it now.
               shreg_q <= fifo_rd_data;
               par_q   <= parity_d;
               baud_q  <= '0;
               tx_q    <= 1'b0;
               state_q <= START;
            end
            START: begin
               if (bit_end_d) begin
                  baud_q  <= '0;
                  bit_q   <= '0;
                  tx_q    <= shreg_q[0];
                  state_q <= DATA;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            DATA: begin
               if (bit_end_d) begin
                  baud_q <= '0;
                  if (bit_q == 3'd7) begin
                     if (PARITY_EN != 0) begin
                        tx_q    <= par_q;
                        state_q <= PARITY;
                     end else begin
                        tx_q    <= 1'b1;
                        stop_q  <= 1'b0;
                        state_q <= STOP;
                     end
                  end else begin
                     bit_q   <= bit_q + 3'd1;
                     shreg_q <= {1'b0, shreg_q[7:1]};
                     tx_q    <= shreg_q[1];
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            PARITY: begin
               if (bit_end_d) begin
                  baud_q  <= '0;
                  tx_q    <= 1'b1;
                  stop_q  <= 1'b0;
                  state_q <= STOP;
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            STOP: begin
               tx_q <= 1'b1;
               if (bit_end_d) begin
                  baud_q <= '0;
                  if (stop_q == STOP_LAST) begin
                     state_q <= IDLE;
                  end else begin
                     stop_q <= 1'b1;
                  end
               end else begin
                  baud_q <= baud_q + BAUD_W'(1);
               end
            end
            default: begin
               tx_q    <= 1'b1;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// tb_fifo_uart_tx -- directed bench for fifo_uart_tx with CLKS_PER_BIT=4.
// Three instances share clk/reset/tx_enable, each fed by its own small FIFO
// model: #0 no parity, #1 even parity, #2 odd parity. A bit-sampling receiver
// task checks every cycle of each frame against hand-written line patterns.
`timescale 1ns/1ps
module tb_fifo_uart_tx;

   localparam int CPB = 4;

   logic       clk       = 1'b0;
   logic       reset     = 1'b0;
   logic       tx_enable = 1'b0;
   logic [2:0] wr_en     = '0;
   logic [7:0] wr_data [3];

   logic [2:0] rd_en, tx_w, busy_w, done_w, empty_w;
   logic [7:0] rd_data [3];
   logic [7:0] mem [3][16];
   logic [3:0] wp [3];
   logic [3:0] rp [3];
   logic [4:0] cnt [3];

   int cyc  = 0;
   int pops [3];
   int viol = 0;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_dut0 (
      .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo_empty(empty_w[0]),
      .fifo_rd_data(rd_data[0]), .fifo_rd_en(rd_en[0]), .tx(tx_w[0]),
      .busy(busy_w[0]), .frame_done(done_w[0]));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_dut1 (
      .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo_empty(empty_w[1]),
      .fifo_rd_data(rd_data[1]), .fifo_rd_en(rd_en[1]), .tx(tx_w[1]),
      .busy(busy_w[1]), .frame_done(done_w[1]));

   fifo_uart_tx #(.CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_dut2 (
      .clk(clk), .reset(reset), .tx_enable(tx_enable), .fifo_empty(empty_w[2]),
      .fifo_rd_data(rd_data[2]), .fifo_rd_en(rd_en[2]), .tx(tx_w[2]),
      .busy(busy_w[2]), .frame_done(done_w[2]));

   // FIFO model: read_data updates on the edge that samples read_enable.
   always_comb begin
      empty_w = '0;
      for (int i = 0; i < 3; i++) empty_w[i] = (cnt[i] == 5'd0);
   end

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (reset) begin
            wp[i]      <= '0;
            rp[i]      <= '0;
            cnt[i]     <= '0;
            rd_data[i] <= '0;
         end else begin
            if (wr_en[i]) begin
               mem[i][wp[i]] <= wr_data[i];
               wp[i]         <= wp[i] + 4'd1;
            end
            if (rd_en[i] && cnt[i] != 5'd0) begin
               rd_data[i] <= mem[i][rp[i]];
               rp[i]      <= rp[i] + 4'd1;
            end
            cnt[i] <= cnt[i] + {4'd0, wr_en[i]} - {4'd0, (rd_en[i] && cnt[i] != 5'd0)};
         end
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) if (rd_en[i]) pops[i] <= pops[i] + 1;
      if ((rd_en & empty_w) != 3'b000) viol <= viol + 1;
   end

   task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic push(input int i, input logic [7:0] b);
      tick();
      wr_en[i]   = 1'b1;
      wr_data[i] = b;
      tick();
      wr_en[i]   = 1'b0;
   endtask

   // line[k] is the required tx level during frame bit k (bit 0 = start).
   task automatic recv(input int inst, input int nbits, input logic [10:0] line,
                       input logic [7:0] exp_byte, input string tag, output int t_start);
      logic       s  [44];
      logic       dn [44];
      logic       bz [44];
      logic [7:0] rx;
      int         found, done_cnt, done_pos, busy_cnt;
      found   = 0;
      t_start = -1;
      for (int w = 0; w < 300 && found == 0; w++) begin
         @(negedge clk);
         if (tx_w[inst] == 1'b0) found = 1;
      end
      chk_eq({tag, " start seen"}, found, 1);
      if (found == 0) return;
      t_start = cyc;
      for (int k = 0; k < nbits * CPB; k++) begin
         if (k > 0) @(negedge clk);
         s[k]  = tx_w[inst];
         dn[k] = done_w[inst];
         bz[k] = busy_w[inst];
      end
      for (int b = 0; b < nbits; b++)
         chk_eq($sformatf("%s bit%0d", tag, b),
                {s[4*b+3], s[4*b+2], s[4*b+1], s[4*b]}, {4{line[b]}});
      for (int d = 0; d < 8; d++) rx[d] = s[4*(d+1)+2];
      chk_eq({tag, " rx byte"}, rx, exp_byte);
      done_cnt = 0;
      done_pos = -1;
      busy_cnt = 0;
      for (int k = 0; k < nbits * CPB; k++) begin
         if (dn[k]) begin
            done_cnt++;
            done_pos = k;
         end
         if (bz[k]) busy_cnt++;
      end
      chk_eq({tag, " done count"}, done_cnt, 1);
      chk_eq({tag, " done pos"}, done_pos, nbits * CPB - 1);
      chk_eq({tag, " busy all"}, busy_cnt, nbits * CPB);
   endtask

   initial begin
      int t1, t2, p, ones;
      for (int i = 0; i < 3; i++) wr_data[i] = '0;

      // T1 reset
      tx_enable = 1'b1;
      #1 reset = 1'b1;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         chk_eq($sformatf("T1 rst tx %0d", k), tx_w, 3'b111);
         chk_eq($sformatf("T1 rst rd_en %0d", k), rd_en, 3'b000);
         chk_eq($sformatf("T1 rst busy %0d", k), busy_w, 3'b000);
         chk_eq($sformatf("T1 rst done %0d", k), done_w, 3'b000);
      end
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk_eq($sformatf("T1 rel tx %0d", k), tx_w, 3'b111);
         chk_eq($sformatf("T1 rel rd_en %0d", k), rd_en, 3'b000);
         chk_eq($sformatf("T1 rel busy %0d", k), busy_w, 3'b000);
      end

      // T2 single byte 0xCA
      tick();
      tx_enable = 1'b0;
      push(0, 8'hCA);
      p = pops[0];
      tick();
      tx_enable = 1'b1;
      recv(0, 10, 11'h394, 8'hCA, "T2", t1);
      tick();
      chk_eq("T2 pops", pops[0] - p, 1);
      chk_eq("T2 busy after", busy_w[0], 1'b0);
      chk_eq("T2 empty after", empty_w[0], 1'b1);

      // T3 back-to-back 0xCA, 0xAA
      tx_enable = 1'b0;
      push(0, 8'hCA);
      push(0, 8'hAA);
      p = pops[0];
      tick();
      tx_enable = 1'b1;
      recv(0, 10, 11'h394, 8'hCA, "T3a", t1);
      recv(0, 10, 11'h354, 8'hAA, "T3b", t2);
      chk_eq("T3 start spacing", t2 - t1, 42);
      tick();
      chk_eq("T3 pops", pops[0] - p, 2);
      chk_eq("T3 empty", empty_w[0], 1'b1);

      // T4 parity: even on #1, odd on #2
      tx_enable = 1'b0;
      push(1, 8'hAA);
      push(1, 8'h01);
      tick();
      tx_enable = 1'b1;
      recv(1, 11, 11'h554, 8'hAA, "T4 even AA", t1);
      recv(1, 11, 11'h602, 8'h01, "T4 even 01", t2);
      chk_eq("T4 even spacing", t2 - t1, 46);
      tick();
      tx_enable = 1'b0;
      push(2, 8'hAA);
      push(2, 8'h01);
      tick();
      tx_enable = 1'b1;
      recv(2, 11, 11'h754, 8'hAA, "T4 odd AA", t1);
      recv(2, 11, 11'h402, 8'h01, "T4 odd 01", t2);
      chk_eq("T4 odd spacing", t2 - t1, 46);

      // T5 tx_enable gating
      tick();
      tx_enable = 1'b0;
      push(0, 8'hAA);
      push(0, 8'hCA);
      p    = pops[0];
      ones = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (tx_w[0]) ones++;
      end
      chk_eq("T5 idle tx", ones, 100);
      chk_eq("T5 no pop", pops[0] - p, 0);
      chk_eq("T5 idle busy", busy_w[0], 1'b0);
      tick();
      tx_enable = 1'b1;
      fork
         recv(0, 10, 11'h354, 8'hAA, "T5", t1);
         begin
            repeat (20) @(posedge clk);
            #2 tx_enable = 1'b0;
         end
      join
      repeat (60) tick();
      chk_eq("T5 one pop", pops[0] - p, 1);
      chk_eq("T5 byte left", empty_w[0], 1'b0);
      chk_eq("T5 end busy", busy_w[0], 1'b0);
      chk_eq("T5 end tx", tx_w[0], 1'b1);

      // T6 reset during data bit 3 of 0xCA
      tick();
      tx_enable = 1'b1;
      repeat (19) @(posedge clk);
      #2;
      chk_eq("T6 busy before", busy_w[0], 1'b1);
      reset = 1'b1;
      #1;
      chk_eq("T6 async tx", tx_w[0], 1'b1);
      chk_eq("T6 async busy", busy_w[0], 1'b0);
      chk_eq("T6 async rd_en", rd_en[0], 1'b0);
      chk_eq("T6 async done", done_w[0], 1'b0);
      repeat (2) @(posedge clk);
      #2 reset = 1'b0;
      p    = pops[0];
      ones = 0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         if (tx_w[0]) ones++;
      end
      chk_eq("T6 idle after rel", ones, 10);
      chk_eq("T6 no pop after rel", pops[0] - p, 0);
      push(0, 8'hCA);
      recv(0, 10, 11'h394, 8'hCA, "T6", t1);

      tick();
      chk_eq("pop while empty", viol, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
